// File: rtl/pq_pkg.sv
// pq_pkg: shared types and defaults for the priority-queue command front end
package pq_pkg;
  localparam int DEFAULT_DATA_WIDTH = 16;
  typedef enum logic {IDLE, SETTLE} state_e;
  typedef enum logic [1:0] {OP_NONE, OP_ENQ, OP_DEQ, OP_REP} op_e;
endpackage

// File: rtl/pq_result_reg.sv
// pq_result_reg: one-entry valid/ready holding register for the popped key
//   i_CLK, i_RSTn      clock, async active-low reset
//   load, load_data    capture a new key (caller only loads when the slot is free or draining)
//   res_valid/ready    output handshake; res_data is held stable while res_valid && !res_ready
module pq_result_reg
  import pq_pkg::*;
#(
  parameter int W = DEFAULT_DATA_WIDTH
) (
  input  logic         i_CLK,
  input  logic         i_RSTn,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         res_ready,
  output logic         res_valid,
  output logic [W-1:0] res_data
);
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (load) begin
      res_valid <= 1'b1;
      res_data  <= load_data;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pq_cmd_frontend.sv
// pq_cmd_frontend: turns enq/deq valid-ready streams into one-cycle queue strobes with a settle gap
//   i_CLK, i_RSTn                          clock, async active-low reset
//   i_enq_valid/o_enq_ready/i_enq_data     keys to insert
//   i_deq_valid/o_deq_ready                pop requests
//   o_res_valid/i_res_ready/o_res_data     popped keys
//   o_pq_wrt/o_pq_read/o_pq_data           registered one-cycle queue strobes and write data
//   i_pq_full/i_pq_empty/i_pq_top          queue status and root key
//   PQ_FRONTEND_ZERO_FILTER_EN             accept-and-drop zero keys, counted in drop_cnt
module pq_cmd_frontend
  import pq_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic                  i_enq_valid,
  output logic                  o_enq_ready,
  input  logic [DATA_WIDTH-1:0] i_enq_data,
  input  logic                  i_deq_valid,
  output logic                  o_deq_ready,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [DATA_WIDTH-1:0] o_res_data,
  output logic                  o_pq_wrt,
  output logic                  o_pq_read,
  output logic [DATA_WIDTH-1:0] o_pq_data,
  input  logic                  i_pq_full,
  input  logic                  i_pq_empty,
  input  logic [DATA_WIDTH-1:0] i_pq_top
);
  state_e     state, state_d;
  op_e        op;
  logic [3:0] cnt, cnt_d;
  logic       enq_nz, deq_ok, drop;
  assign enq_nz = i_enq_valid && i_enq_data != '0;
  // a pop needs a free result slot, or one being drained this very cycle
  assign deq_ok = i_deq_valid && !i_pq_empty && (!o_res_valid || i_res_ready);
`ifdef PQ_FRONTEND_ZERO_FILTER_EN
  logic [7:0] drop_cnt;
  assign drop = state == IDLE && i_enq_valid && i_enq_data == '0;
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
  end
`else
  assign drop = 1'b0;
  assert property (@(posedge i_CLK) disable iff (!i_RSTn) !(i_enq_valid && i_enq_data == '0));
`endif
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end
  // a full queue still takes a replace, since it pops before it pushes
  always_comb begin
    op      = OP_NONE;
    state_d = state;
    cnt_d   = cnt;
    if (state == IDLE)
      op = enq_nz && deq_ok ? OP_REP : enq_nz && !i_pq_full ? OP_ENQ : deq_ok ? OP_DEQ : OP_NONE;
    if (op != OP_NONE) begin
      state_d = SETTLE;
      cnt_d   = 4'(SETTLE_CYCLES);
    end else if (state == SETTLE) begin
      state_d = cnt == '0 ? IDLE : SETTLE;
      cnt_d   = cnt == '0 ? cnt : cnt - 4'd1;
    end
    o_enq_ready = op == OP_ENQ || op == OP_REP || drop;
    o_deq_ready = op == OP_DEQ || op == OP_REP;
  end
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      o_pq_wrt  <= 1'b0;
      o_pq_read <= 1'b0;
      o_pq_data <= '0;
    end else begin
      o_pq_wrt  <= op == OP_ENQ || op == OP_REP;
      o_pq_read <= op == OP_DEQ || op == OP_REP;
      if (op == OP_ENQ || op == OP_REP) o_pq_data <= i_enq_data;
    end
  end
  pq_result_reg #(.W(DATA_WIDTH)) u_res (
    .i_CLK    (i_CLK),
    .i_RSTn   (i_RSTn),
    .load     (o_deq_ready),
    .load_data(i_pq_top),
    .res_ready(i_res_ready),
    .res_valid(o_res_valid),
    .res_data (o_res_data)
  );
endmodule

// File: tb/tb_pq_cmd_frontend.sv
// tb_pq_cmd_frontend: directed checks of the command front end, with the bench playing the queue
module tb_pq_cmd_frontend;
  localparam int W = 16;
  logic         i_CLK = 1'b0;
  logic         i_RSTn = 1'b0;
  logic         i_enq_valid = 1'b0;
  logic         o_enq_ready;
  logic [W-1:0] i_enq_data = 16'h1;
  logic         i_deq_valid = 1'b0;
  logic         o_deq_ready;
  logic         o_res_valid;
  logic         i_res_ready = 1'b0;
  logic [W-1:0] o_res_data;
  logic         o_pq_wrt;
  logic         o_pq_read;
  logic [W-1:0] o_pq_data;
  logic         i_pq_full = 1'b0;
  logic         i_pq_empty = 1'b1;
  logic [W-1:0] i_pq_top = '0;
  int checks = 0;
  int errors = 0;
  pq_cmd_frontend #(.DATA_WIDTH(W), .SETTLE_CYCLES(2)) dut (
    .i_CLK      (i_CLK),
    .i_RSTn     (i_RSTn),
    .i_enq_valid(i_enq_valid),
    .o_enq_ready(o_enq_ready),
    .i_enq_data (i_enq_data),
    .i_deq_valid(i_deq_valid),
    .o_deq_ready(o_deq_ready),
    .o_res_valid(o_res_valid),
    .i_res_ready(i_res_ready),
    .o_res_data (o_res_data),
    .o_pq_wrt   (o_pq_wrt),
    .o_pq_read  (o_pq_read),
    .o_pq_data  (o_pq_data),
    .i_pq_full  (i_pq_full),
    .i_pq_empty (i_pq_empty),
    .i_pq_top   (i_pq_top)
  );
  always #5 i_CLK = ~i_CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge i_CLK);
    #1;
  endtask
  task automatic chk_idle_outs(input string tag);
    chk({tag, "_wrt"}, o_pq_wrt, 0);
    chk({tag, "_read"}, o_pq_read, 0);
    chk({tag, "_pqdata"}, o_pq_data, 0);
    chk({tag, "_resv"}, o_res_valid, 0);
    chk({tag, "_resd"}, o_res_data, 0);
    chk({tag, "_enqrdy"}, o_enq_ready, 0);
    chk({tag, "_deqrdy"}, o_deq_ready, 0);
  endtask
  logic [W-1:0] enq_vals [3] = '{16'd5, 16'd9, 16'd3};
  logic [W-1:0] enq_tops [3] = '{16'd5, 16'd9, 16'd9};
  logic [W-1:0] deq_vals [3] = '{16'd9, 16'd5, 16'd3};
  logic [W-1:0] deq_tops [3] = '{16'd5, 16'd3, 16'd0};
  initial begin
    repeat (2) step;
    chk_idle_outs("reset");
    i_RSTn = 1'b1;
    step;
    // enq 5, 9, 3: one wrt per op, 4 cycles apart, data held across input changes
    i_enq_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_enq_data = enq_vals[k];
      #1;
      chk("enq_rdy", o_enq_ready, 1);
      chk("enq_deqrdy", o_deq_ready, 0);
      step;
      chk("enq_wrt", o_pq_wrt, 1);
      chk("enq_read", o_pq_read, 0);
      chk("enq_data", o_pq_data, enq_vals[k]);
      i_pq_empty = 1'b0;
      i_pq_top = enq_tops[k];
      i_enq_data = 16'h77;
      for (int i = 1; i <= 3; i++) begin
        step;
        chk("gap_wrt", o_pq_wrt, 0);
        chk("gap_rdy", o_enq_ready, i == 3);
        chk("gap_data", o_pq_data, enq_vals[k]);
      end
      if (k == 2) i_enq_valid = 1'b0;
    end
    // deq three times: 9, 5, 3
    i_res_ready = 1'b1;
    i_deq_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("deq_rdy", o_deq_ready, 1);
      chk("deq_enqrdy", o_enq_ready, 0);
      step;
      chk("deq_read", o_pq_read, 1);
      chk("deq_wrt", o_pq_wrt, 0);
      chk("deq_resv", o_res_valid, 1);
      chk("deq_resd", o_res_data, deq_vals[k]);
      i_pq_top = deq_tops[k];
      if (k == 2) i_pq_empty = 1'b1;
      step;
      chk("deq_drained", o_res_valid, 0);
      repeat (2) step;
    end
    i_deq_valid = 1'b0;
    // replace with queue {7}
    i_pq_empty = 1'b0;
    i_pq_top = 16'd7;
    i_enq_valid = 1'b1;
    i_enq_data = 16'd4;
    i_deq_valid = 1'b1;
    #1;
    chk("rep_enqrdy", o_enq_ready, 1);
    chk("rep_deqrdy", o_deq_ready, 1);
    step;
    chk("rep_wrt", o_pq_wrt, 1);
    chk("rep_read", o_pq_read, 1);
    chk("rep_data", o_pq_data, 4);
    chk("rep_resd", o_res_data, 7);
    i_enq_valid = 1'b0;
    i_deq_valid = 1'b0;
    i_pq_top = 16'd4;
    step;
    chk("rep_once_wrt", o_pq_wrt, 0);
    chk("rep_once_read", o_pq_read, 0);
    repeat (2) step;
    // full, no deq: stall; then deq forms a replace
    i_pq_full = 1'b1;
    i_enq_valid = 1'b1;
    i_enq_data = 16'd8;
    #1;
    chk("full_enqrdy", o_enq_ready, 0);
    repeat (2) begin
      step;
      chk("full_wrt", o_pq_wrt, 0);
      chk("full_stall", o_enq_ready, 0);
    end
    i_deq_valid = 1'b1;
    #1;
    chk("full_rep_enqrdy", o_enq_ready, 1);
    chk("full_rep_deqrdy", o_deq_ready, 1);
    step;
    chk("full_rep_wrt", o_pq_wrt, 1);
    chk("full_rep_read", o_pq_read, 1);
    chk("full_rep_data", o_pq_data, 8);
    chk("full_rep_resd", o_res_data, 4);
    i_enq_valid = 1'b0;
    i_deq_valid = 1'b0;
    i_pq_full = 1'b0;
    i_pq_top = 16'd8;
    repeat (3) step;
    i_deq_valid = 1'b1;
    #1;
    step;
    chk("drain8_resd", o_res_data, 8);
    i_deq_valid = 1'b0;
    i_pq_empty = 1'b1;
    i_pq_top = '0;
    repeat (3) step;
    // empty: deq waits, enq 2 goes alone, deq follows after the gap
    i_deq_valid = 1'b1;
    #1;
    chk("empty_deqrdy", o_deq_ready, 0);
    repeat (2) begin
      step;
      chk("empty_read", o_pq_read, 0);
    end
    i_enq_valid = 1'b1;
    i_enq_data = 16'd2;
    #1;
    chk("empty_enqrdy", o_enq_ready, 1);
    chk("empty_deqwait", o_deq_ready, 0);
    step;
    chk("empty_wrt", o_pq_wrt, 1);
    chk("empty_noread", o_pq_read, 0);
    chk("empty_data", o_pq_data, 2);
    i_enq_valid = 1'b0;
    i_pq_empty = 1'b0;
    i_pq_top = 16'd2;
    for (int i = 1; i <= 3; i++) begin
      step;
      chk("empty_gap_deqrdy", o_deq_ready, i == 3);
    end
    step;
    chk("empty_read2", o_pq_read, 1);
    chk("empty_resv", o_res_valid, 1);
    chk("empty_resd", o_res_data, 2);
    i_deq_valid = 1'b0;
    i_pq_empty = 1'b1;
    repeat (3) step;
    // result back-pressure
    i_res_ready = 1'b0;
    i_pq_empty = 1'b0;
    i_pq_top = 16'd6;
    i_deq_valid = 1'b1;
    #1;
    chk("bp_deqrdy", o_deq_ready, 1);
    step;
    chk("bp_read", o_pq_read, 1);
    chk("bp_resd", o_res_data, 6);
    i_pq_top = 16'd1;
    for (int i = 1; i <= 5; i++) begin
      step;
      chk("bp_blocked", o_deq_ready, 0);
      chk("bp_noread", o_pq_read, 0);
      chk("bp_resv", o_res_valid, 1);
      chk("bp_stable", o_res_data, 6);
    end
    i_res_ready = 1'b1;
    #1;
    chk("bp_drain_rdy", o_deq_ready, 1);
    step;
    chk("bp_read2", o_pq_read, 1);
    chk("bp_resv2", o_res_valid, 1);
    chk("bp_resd2", o_res_data, 1);
    i_deq_valid = 1'b0;
    i_pq_empty = 1'b1;
    step;
    chk("bp_resv_drop", o_res_valid, 0);
    repeat (2) step;
    // reset mid-settle with a result pending
    i_res_ready = 1'b0;
    i_pq_empty = 1'b0;
    i_pq_top = 16'd3;
    i_deq_valid = 1'b1;
    #1;
    step;
    chk("rst_pre_resv", o_res_valid, 1);
    chk("rst_pre_resd", o_res_data, 3);
    i_deq_valid = 1'b0;
    i_pq_empty = 1'b1;
    step;
    i_RSTn = 1'b0;
    #1;
    chk_idle_outs("midrst");
    step;
    i_RSTn = 1'b1;
    i_enq_valid = 1'b1;
    i_enq_data = 16'd5;
    #1;
    chk("post_rst_idle", o_enq_ready, 1);
    step;
    chk("post_rst_wrt", o_pq_wrt, 1);
    chk("post_rst_data", o_pq_data, 5);
    i_enq_valid = 1'b0;
    repeat (3) step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
